// File: rtl/pmp_check_arbiter.sv
// Shares one PMP compare datapath between fetch (IF) and LSU check requests, with 1-cycle response slots.
// Optional PMP_ARB_RR_EN: round-robin tie-break; otherwise LSU has fixed priority over IF.
module pmp_check_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_vld,
  output logic                  if_req_rdy,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_vld,
  input  logic                  if_rsp_rdy,
  output logic                  if_rsp_pass,
  input  logic                  lsu_req_vld,
  output logic                  lsu_req_rdy,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic                  lsu_req_wr,
  output logic                  lsu_rsp_vld,
  input  logic                  lsu_rsp_rdy,
  output logic                  lsu_rsp_pass,
  input  logic                  csr_wr_pend,
  output logic [ADDR_WIDTH-1:0] chk_addr,
  output logic [1:0]            chk_req_mode,
  input  logic                  chk_pass,
  output logic [CNT_WIDTH-1:0]  deny_cnt
);

  localparam int CH_IF  = 0;
  localparam int CH_LSU = 1;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_STORE = 2'b10;
  localparam logic [1:0] MODE_FETCH = 2'b11;

  logic [1:0] req_vld;
  logic [1:0] rsp_rdy;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic [1:0] rsp_vld_reg;
  logic [1:0] rsp_pass_reg;
  logic [CNT_WIDTH-1:0] deny_cnt_reg;
  logic gnt_any;

  assign req_vld = {lsu_req_vld, if_req_vld};
  assign rsp_rdy = {lsu_rsp_rdy, if_rsp_rdy};

  // A slot is free if empty or being drained this very cycle (full throughput).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req_vld[gi] && !csr_wr_pend && (!rsp_vld_reg[gi] || rsp_rdy[gi]);
    end
  endgenerate

`ifdef PMP_ARB_RR_EN
  typedef enum logic {GNT_IF = 1'b0, GNT_LSU = 1'b1} gnt_e;
  gnt_e last_gnt_reg, last_gnt_next;

  always_comb begin
    gnt = 2'b00;
    last_gnt_next = last_gnt_reg;
    if (elig[CH_IF] && (!elig[CH_LSU] || last_gnt_reg == GNT_LSU)) begin
      gnt[CH_IF] = 1'b1;
      last_gnt_next = GNT_IF;
    end else if (elig[CH_LSU]) begin
      gnt[CH_LSU] = 1'b1;
      last_gnt_next = GNT_LSU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_reg <= GNT_LSU;
    end else begin
      last_gnt_reg <= last_gnt_next;
    end
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (elig[CH_LSU]) begin
      gnt[CH_LSU] = 1'b1;
    end else if (elig[CH_IF]) begin
      gnt[CH_IF] = 1'b1;
    end
  end
`endif

  assign gnt_any = |gnt;

  always_comb begin
    chk_addr     = '0;
    chk_req_mode = MODE_IDLE;
    if (gnt[CH_IF]) begin
      chk_addr     = if_req_addr;
      chk_req_mode = MODE_FETCH;
    end else if (gnt[CH_LSU]) begin
      chk_addr     = lsu_req_addr;
      chk_req_mode = lsu_req_wr ? MODE_STORE : MODE_LOAD;
    end
  end

  // Response slots: a new grant refills, otherwise a handshake empties; pass is held meanwhile.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_vld_reg[gi]  <= 1'b0;
          rsp_pass_reg[gi] <= 1'b0;
        end else if (gnt[gi]) begin
          rsp_vld_reg[gi]  <= 1'b1;
          rsp_pass_reg[gi] <= chk_pass;
        end else if (rsp_vld_reg[gi] && rsp_rdy[gi]) begin
          rsp_vld_reg[gi]  <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      deny_cnt_reg <= '0;
    end else if (gnt_any && !chk_pass && deny_cnt_reg != {CNT_WIDTH{1'b1}}) begin
      deny_cnt_reg <= deny_cnt_reg + 1'b1;
    end
  end

  assign if_req_rdy   = gnt[CH_IF];
  assign lsu_req_rdy  = gnt[CH_LSU];
  assign if_rsp_vld   = rsp_vld_reg[CH_IF];
  assign if_rsp_pass  = rsp_pass_reg[CH_IF];
  assign lsu_rsp_vld  = rsp_vld_reg[CH_LSU];
  assign lsu_rsp_pass = rsp_pass_reg[CH_LSU];
  assign deny_cnt     = deny_cnt_reg;

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Self-checking bench for pmp_check_arbiter: directed vector table, corner sequences, randomized model run.
module tb_pmp_check_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_vld, if_req_rdy, if_rsp_vld, if_rsp_rdy, if_rsp_pass;
  logic [31:0] if_req_addr;
  logic        lsu_req_vld, lsu_req_rdy, lsu_req_wr, lsu_rsp_vld, lsu_rsp_rdy, lsu_rsp_pass;
  logic [31:0] lsu_req_addr;
  logic        csr_wr_pend;
  logic [31:0] chk_addr;
  logic [1:0]  chk_req_mode;
  logic        chk_pass;
  logic [15:0] deny_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pmp_check_arbiter #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .if_req_vld(if_req_vld), .if_req_rdy(if_req_rdy), .if_req_addr(if_req_addr),
    .if_rsp_vld(if_rsp_vld), .if_rsp_rdy(if_rsp_rdy), .if_rsp_pass(if_rsp_pass),
    .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wr(lsu_req_wr), .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_rdy(lsu_rsp_rdy),
    .lsu_rsp_pass(lsu_rsp_pass), .csr_wr_pend(csr_wr_pend),
    .chk_addr(chk_addr), .chk_req_mode(chk_req_mode), .chk_pass(chk_pass),
    .deny_cnt(deny_cnt)
  );

  // Reference model: per-channel response slot (0 = IF, 1 = LSU), last winner, deny total.
  bit m_full[2];
  bit m_pass[2];
  int m_last;
  int m_deny;
  int m_win;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req_vld = 0; if_req_addr = 0; if_rsp_rdy = 1;
    lsu_req_vld = 0; lsu_req_addr = 0; lsu_req_wr = 0; lsu_rsp_rdy = 1;
    csr_wr_pend = 0; chk_pass = 1;
  endtask

  task automatic model_reset();
    m_full = '{0, 0}; m_pass = '{0, 0}; m_last = 1; m_deny = 0; m_win = -1;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  // Inputs are already applied (1 time unit after posedge); compare mid-cycle, then advance.
  task automatic step(input bit do_chk);
    bit elig[2];
    bit vld[2];
    bit rrdy[2];
    logic [1:0]  e_mode;
    logic [31:0] e_addr;
    vld  = '{if_req_vld, lsu_req_vld};
    rrdy = '{if_rsp_rdy, lsu_rsp_rdy};
    #4;
    for (int c = 0; c < 2; c++) elig[c] = vld[c] && !csr_wr_pend && (!m_full[c] || rrdy[c]);
    if (elig[0] && elig[1]) begin
`ifdef PMP_ARB_RR_EN
      m_win = 1 - m_last;
`else
      m_win = 1;
`endif
    end else if (elig[0]) m_win = 0;
    else if (elig[1]) m_win = 1;
    else m_win = -1;
    e_mode = (m_win == 0) ? 2'd3 : (m_win == 1) ? (lsu_req_wr ? 2'd2 : 2'd1) : 2'd0;
    e_addr = (m_win == 0) ? if_req_addr : (m_win == 1) ? lsu_req_addr : 32'd0;
    if (do_chk) begin
      check("if_req_rdy",   32'(if_req_rdy),   32'(m_win == 0));
      check("lsu_req_rdy",  32'(lsu_req_rdy),  32'(m_win == 1));
      check("chk_req_mode", 32'(chk_req_mode), 32'(e_mode));
      check("chk_addr",     chk_addr,          e_addr);
      check("if_rsp_vld",   32'(if_rsp_vld),   32'(m_full[0]));
      check("if_rsp_pass",  32'(if_rsp_pass),  32'(m_pass[0]));
      check("lsu_rsp_vld",  32'(lsu_rsp_vld),  32'(m_full[1]));
      check("lsu_rsp_pass", 32'(lsu_rsp_pass), 32'(m_pass[1]));
      check("deny_cnt",     32'(deny_cnt),     32'(m_deny));
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (m_win == c) begin
        m_full[c] = 1; m_pass[c] = chk_pass;
      end else if (m_full[c] && rrdy[c]) begin
        m_full[c] = 0;
      end
    end
    if (m_win >= 0) begin
      m_last = m_win;
      if (!chk_pass && m_deny < 65535) m_deny++;
    end
    #1;
  endtask

  typedef struct {
    logic iv; logic [31:0] ia; logic lv; logic [31:0] la; logic lw;
    logic ir; logic lr; logic pend; logic cp;
    logic e_ird; logic e_lrd; logic [1:0] e_mode; logic [31:0] e_addr;
    logic e_iv; logic e_ip; logic e_lv; logic e_lp; logic [15:0] e_deny;
  } vec_t;

  vec_t tbl[18];

  initial begin
    bit hold_if, hold_lsu;

    // Directed table starting from reset: last_gnt = LSU, deny = 0.
    //            iv ia            lv la        lw ir lr pd cp | ird lrd mode addr         iv ip lv lp deny
    tbl[0]  = '{1, 32'h8000_0000, 0, 0,        0, 1, 1, 0, 1,   1, 0, 3, 32'h8000_0000, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0,             0, 0,        0, 1, 1, 0, 0,   0, 0, 0, 0,             1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0,             1, 32'h1000, 1, 1, 1, 0, 0,   0, 1, 2, 32'h1000,      0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0,             0, 0,        0, 1, 1, 0, 0,   0, 0, 0, 0,             0, 1, 1, 0, 1};
    tbl[4]  = '{0, 0,             1, 32'h2000, 0, 1, 0, 0, 1,   0, 1, 1, 32'h2000,      0, 1, 0, 0, 1};
    tbl[5]  = '{0, 0,             1, 32'h3000, 0, 1, 0, 0, 0,   0, 0, 0, 0,             0, 1, 1, 1, 1};
    tbl[6]  = '{0, 0,             1, 32'h3000, 0, 1, 0, 0, 0,   0, 0, 0, 0,             0, 1, 1, 1, 1};
    tbl[7]  = '{0, 0,             1, 32'h3000, 0, 1, 0, 0, 0,   0, 0, 0, 0,             0, 1, 1, 1, 1};
    tbl[8]  = '{0, 0,             1, 32'h3000, 0, 1, 1, 0, 0,   0, 1, 1, 32'h3000,      0, 1, 1, 1, 1};
    tbl[9]  = '{0, 0,             0, 0,        0, 1, 1, 0, 1,   0, 0, 0, 0,             0, 1, 1, 0, 2};
    tbl[10] = '{1, 32'h4000,      0, 0,        0, 1, 1, 0, 1,   1, 0, 3, 32'h4000,      0, 1, 0, 0, 2};
    tbl[11] = '{1, 32'h5000,      1, 32'h6000, 1, 0, 1, 1, 1,   0, 0, 0, 0,             1, 1, 0, 0, 2};
    tbl[12] = '{1, 32'h5000,      1, 32'h6000, 1, 1, 1, 1, 1,   0, 0, 0, 0,             1, 1, 0, 0, 2};
    tbl[13] = '{1, 32'h5000,      1, 32'h6000, 1, 1, 1, 1, 1,   0, 0, 0, 0,             0, 1, 0, 0, 2};
    tbl[14] = '{1, 32'h5000,      1, 32'h6000, 1, 1, 1, 1, 1,   0, 0, 0, 0,             0, 1, 0, 0, 2};
    tbl[15] = '{1, 32'h5000,      1, 32'h6000, 1, 1, 1, 0, 1,   0, 1, 2, 32'h6000,      0, 1, 0, 0, 2};
`ifdef PMP_ARB_RR_EN
    tbl[16] = '{1, 32'h5000,      1, 32'h6000, 1, 1, 1, 0, 0,   1, 0, 3, 32'h5000,      0, 1, 1, 1, 2};
    tbl[17] = '{0, 0,             0, 0,        0, 1, 1, 0, 1,   0, 0, 0, 0,             1, 0, 0, 1, 3};
`else
    tbl[16] = '{1, 32'h5000,      1, 32'h6000, 1, 1, 1, 0, 0,   0, 1, 2, 32'h6000,      0, 1, 1, 1, 2};
    tbl[17] = '{0, 0,             0, 0,        0, 1, 1, 0, 1,   0, 0, 0, 0,             0, 1, 1, 0, 3};
`endif

    do_reset();
    for (int i = 0; i < 18; i++) begin
      if_req_vld = tbl[i].iv; if_req_addr = tbl[i].ia;
      lsu_req_vld = tbl[i].lv; lsu_req_addr = tbl[i].la; lsu_req_wr = tbl[i].lw;
      if_rsp_rdy = tbl[i].ir; lsu_rsp_rdy = tbl[i].lr;
      csr_wr_pend = tbl[i].pend; chk_pass = tbl[i].cp;
      #4;
      check($sformatf("vec%0d if_req_rdy", i),   32'(if_req_rdy),   32'(tbl[i].e_ird));
      check($sformatf("vec%0d lsu_req_rdy", i),  32'(lsu_req_rdy),  32'(tbl[i].e_lrd));
      check($sformatf("vec%0d chk_req_mode", i), 32'(chk_req_mode), 32'(tbl[i].e_mode));
      check($sformatf("vec%0d chk_addr", i),     chk_addr,          tbl[i].e_addr);
      check($sformatf("vec%0d if_rsp_vld", i),   32'(if_rsp_vld),   32'(tbl[i].e_iv));
      check($sformatf("vec%0d if_rsp_pass", i),  32'(if_rsp_pass),  32'(tbl[i].e_ip));
      check($sformatf("vec%0d lsu_rsp_vld", i),  32'(lsu_rsp_vld),  32'(tbl[i].e_lv));
      check($sformatf("vec%0d lsu_rsp_pass", i), 32'(lsu_rsp_pass), 32'(tbl[i].e_lp));
      check($sformatf("vec%0d deny_cnt", i),     32'(deny_cnt),     32'(tbl[i].e_deny));
      $display("vec %0d: ird=%0d lrd=%0d mode=%0d addr=%h deny=%0d", i, if_req_rdy, lsu_req_rdy,
               chk_req_mode, chk_addr, deny_cnt);
      @(posedge clk); #1;
    end

    // Continuous contention: alternation with round-robin, LSU every cycle otherwise.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if_req_vld = 1; if_req_addr = 32'h100 + k; lsu_req_vld = 1; lsu_req_addr = 32'h200 + k;
      lsu_req_wr = 0; if_rsp_rdy = 1; lsu_rsp_rdy = 1; chk_pass = 1;
      #4;
`ifdef PMP_ARB_RR_EN
      check($sformatf("alt%0d if_req_rdy", k), 32'(if_req_rdy), 32'(k % 2 == 0));
`else
      check($sformatf("alt%0d if_req_rdy", k), 32'(if_req_rdy), 32'd0);
`endif
      check($sformatf("alt%0d lsu_req_rdy", k), 32'(lsu_req_rdy), 32'(!if_req_rdy));
      $display("alt %0d: ird=%0d lrd=%0d", k, if_req_rdy, lsu_req_rdy);
      @(posedge clk); #1;
    end

    // Mid-operation reset drops a full slot; request accepted in the reset cycle yields nothing.
    idle_inputs();
    lsu_req_vld = 1; lsu_rsp_rdy = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; lsu_req_vld = 0;
    #4;
    check("rst_drop lsu_rsp_vld", 32'(lsu_rsp_vld), 32'd0);
    check("rst_drop if_rsp_vld",  32'(if_rsp_vld),  32'd0);
    check("rst_drop deny_cnt",    32'(deny_cnt),    32'd0);
    $display("reset drop: lsu_rsp_vld=%0d if_rsp_vld=%0d", lsu_rsp_vld, if_rsp_vld);
    @(posedge clk); #1;

    // Randomized run against the model, with occasional resets and the stability rule honoured.
    do_reset();
    hold_if = 0; hold_lsu = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold_if) if_req_addr = $urandom;
      if (!hold_lsu) begin
        lsu_req_addr = $urandom; lsu_req_wr = 1'($urandom_range(0, 1));
      end
      if_req_vld  = ($urandom_range(0, 99) < 60);
      lsu_req_vld = ($urandom_range(0, 99) < 60);
      if_rsp_rdy  = ($urandom_range(0, 99) < 70);
      lsu_rsp_rdy = ($urandom_range(0, 99) < 70);
      csr_wr_pend = ($urandom_range(0, 99) < 10);
      chk_pass    = 1'($urandom_range(0, 1));
      if (n % 1000 == 999) begin
        do_reset();
        hold_if = 0; hold_lsu = 0;
      end else begin
        step(1);
        hold_if  = if_req_vld && (m_win != 0);
        hold_lsu = lsu_req_vld && (m_win != 1);
        if (n % 100 == 0) $display("rand %0d: win=%0d deny=%0d", n, m_win, m_deny);
      end
    end

    // Deny counter saturation: 65535 denials, then one more.
    do_reset();
    lsu_req_vld = 1; lsu_req_addr = 32'h1000; lsu_req_wr = 1; lsu_rsp_rdy = 1; chk_pass = 0;
    for (int n = 0; n < 65535; n++) step(0);
    #4;
    check("sat deny_cnt full", 32'(deny_cnt), 32'hFFFF);
    @(posedge clk); #1;
    #4;
    check("sat deny_cnt held", 32'(deny_cnt), 32'hFFFF);
    check("sat lsu_rsp_pass",  32'(lsu_rsp_pass), 32'd0);
    $display("saturate: deny_cnt=%h", deny_cnt);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
